// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared MMIO offsets, status bit positions and region select
package dmem_pkg;

  localparam logic [7:0] OFF_CYCLE  = 8'h00;
  localparam logic [7:0] OFF_LED    = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_COUNT  = 8'h10;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_UNMAPPED
  } region_e;

endpackage

// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - circular console transmit FIFO with valid/ready drain
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             push_rejected
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok, push_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  // A pop frees the slot this cycle, so a push at full is still accepted.
  assign pop_ok        = pop && !empty;
  assign push_ok       = push && (!full || pop_ok);
  assign push_rejected = push && !push_ok;

  assign head = empty ? '0 : mem_q[rd_q];

  always_comb begin
    rd_d    = rd_q + AW'(pop_ok);
    wr_d    = wr_q + AW'(push_ok);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory bus responder: RAM, cycle counter, LED and console FIFO
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int          MEM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] MMIO_PAGE  = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_out,
  input  logic        data_wr,
  output logic [31:0] data_in,
  output logic        mem_fault,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  led
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   ram_q [MEM_WORDS];
  logic [31:0]   cycle_q, cycle_d;
  logic [7:0]    led_q, led_d;
  logic          ovf_q, ovf_d;
  logic          fault_q, fault_d;
  region_e       region;
  logic [7:0]    off;
  logic [AW-1:0] idx;
  logic          mmio_wr, off_known, push;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty, push_rejected;

  always_comb begin
    region = REG_UNMAPPED;
    if (data_addr[31:16] == MMIO_PAGE) begin
      region = REG_MMIO;
    end else if ({2'b00, data_addr[31:2]} < 32'(MEM_WORDS)) begin
      region = REG_RAM;
    end
  end

  assign off       = data_addr[7:0] & 8'hFC;
  assign idx       = data_addr[AW+1:2];
  assign mmio_wr   = data_wr && (region == REG_MMIO);
  assign off_known = off inside {OFF_CYCLE, OFF_LED, OFF_TXDATA, OFF_STATUS, OFF_COUNT};
  assign push      = mmio_wr && (off == OFF_TXDATA);

  tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk           (clk),
    .rst           (rst),
    .push          (push),
    .push_data     (data_out[7:0]),
    .pop           (tx_ready),
    .head          (tx_data),
    .count         (fifo_count),
    .full          (fifo_full),
    .empty         (fifo_empty),
    .push_rejected (push_rejected)
  );

  assign tx_valid  = !fifo_empty;
  assign led       = led_q;
  assign mem_fault = fault_q;

  always_ff @(posedge clk) begin
    if (data_wr && (region == REG_RAM)) begin
      ram_q[idx] <= data_out;
    end
  end

  always_comb begin
    cycle_d = cycle_q + 32'd1;
    led_d   = led_q;
    ovf_d   = ovf_q;
    fault_d = fault_q;
    if (mmio_wr && off == OFF_LED) begin
      led_d = data_out[7:0];
    end
    if (mmio_wr && off == OFF_STATUS && data_out[ST_OVF]) begin
      ovf_d = 1'b0;
    end
    if (push_rejected) begin
      ovf_d = 1'b1;
    end
    if (data_wr && (region == REG_UNMAPPED || (region == REG_MMIO && !off_known))) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q <= '0;
      led_q   <= '0;
      ovf_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      led_q   <= led_d;
      ovf_q   <= ovf_d;
      fault_q <= fault_d;
    end
  end

  // RAM reads return the pre-write word because the array only updates at the edge.
  always_comb begin
    data_in = '0;
    case (region)
      REG_RAM: data_in = ram_q[idx];
      REG_MMIO: begin
        case (off)
          OFF_CYCLE:  data_in = cycle_q;
          OFF_LED:    data_in = {24'b0, led_q};
          OFF_STATUS: begin
            data_in[ST_EMPTY] = fifo_empty;
            data_in[ST_FULL]  = fifo_full;
            data_in[ST_OVF]   = ovf_q;
          end
          OFF_COUNT:  data_in = {{(32-CW){1'b0}}, fifo_count};
          default:    data_in = '0;
        endcase
      end
      default: data_in = '0;
    endcase
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized bench with a queue-based reference model
`timescale 1ns/100ps
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_addr, data_out, data_in;
  logic        data_wr, mem_fault, tx_valid, tx_ready;
  logic [7:0]  tx_data, led;

  data_mem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .data_addr (data_addr),
    .data_out  (data_out),
    .data_wr   (data_wr),
    .data_in   (data_in),
    .mem_fault (mem_fault),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .led       (led)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference state: plain counters, a byte queue and a word array.
  logic [31:0] m_cyc;
  logic [7:0]  m_led;
  logic        m_ovf, m_fault;
  logic [7:0]  m_q[$];
  logic [31:0] m_ram [1024];
  bit          m_known [1024];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic bit pred(input logic [31:0] a, output logic [31:0] v);
    logic [7:0] o;
    o = a[7:0] & 8'hFC;
    v = 32'h0;
    if (a[31:16] == 16'hFFFF) begin
      case (o)
        8'h00: v = m_cyc;
        8'h04: v = {24'h0, m_led};
        8'h0C: v = {29'h0, m_ovf, m_q.size() == 8, m_q.size() == 0};
        8'h10: v = 32'(m_q.size());
        default: v = 32'h0;
      endcase
      return 1'b1;
    end else if (a[31:2] < 30'd1024) begin
      v = m_ram[a[11:2]];
      return m_known[a[11:2]];
    end
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc = 0; m_led = 0; m_ovf = 0; m_fault = 0;
      m_q.delete();
    end else begin
      bit pop, push, clr;
      logic [7:0] o;
      pop  = tx_ready && m_q.size() > 0;
      push = 0;
      clr  = 0;
      o    = data_addr[7:0] & 8'hFC;
      if (data_wr) begin
        if (data_addr[31:16] == 16'hFFFF) begin
          case (o)
            8'h00, 8'h10: ;
            8'h04: m_led = data_out[7:0];
            8'h08: push = 1;
            8'h0C: clr = data_out[2];
            default: m_fault = 1;
          endcase
        end else if (data_addr[31:2] < 30'd1024) begin
          m_ram[data_addr[11:2]]   = data_out;
          m_known[data_addr[11:2]] = 1;
        end else begin
          m_fault = 1;
        end
      end
      if (clr) m_ovf = 0;
      if (push && !(m_q.size() < 8 || pop)) begin
        m_ovf = 1;
        push = 0;
      end
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(data_out[7:0]);
      m_cyc = m_cyc + 1;
    end
  end

  always @(negedge clk) begin
    logic [31:0] v;
    if (!rst) begin
      if (pred(data_addr, v)) chk("data_in", data_in, v);
      chk("led", {24'h0, led}, {24'h0, m_led});
      chk("mem_fault", {31'h0, mem_fault}, {31'h0, m_fault});
      chk("tx_valid", {31'h0, tx_valid}, {31'h0, m_q.size() != 0});
      if (m_q.size() != 0) chk("tx_data", {24'h0, tx_data}, {24'h0, m_q[0]});
    end
  end

  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r,
                     input logic rv);
    @(posedge clk);
    #1;
    data_addr = a; data_out = d; data_wr = w; tx_ready = r; rst = rv;
    #1;
  endtask

  localparam logic [31:0] A_CYC = 32'hFFFF_0000, A_LED = 32'hFFFF_0004,
                          A_TX = 32'hFFFF_0008, A_ST = 32'hFFFF_000C, A_CNT = 32'hFFFF_0010;

  initial begin
    rst = 1; data_addr = A_CYC; data_out = 0; data_wr = 0; tx_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cycle", data_in, 32'h0);
    chk("rst_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_txdata", {24'h0, tx_data}, 32'h0);
    chk("rst_led", {24'h0, led}, 32'h0);
    chk("rst_fault", {31'h0, mem_fault}, 32'h0);
    rst = 0;
    repeat (5) @(posedge clk);
    #2 chk("cycle5", data_in, 32'd5);

    cyc(32'h10, 32'hDEADBEEF, 1, 0, 0);
    cyc(32'h10, 0, 0, 0, 0);            chk("ram_rd", data_in, 32'hDEADBEEF);
    cyc(32'h13, 0, 0, 0, 0);            chk("ram_rd13", data_in, 32'hDEADBEEF);
    cyc(32'h10, 32'h1, 1, 0, 0);        chk("ram_rdw_old", data_in, 32'hDEADBEEF);
    cyc(32'h10, 0, 0, 0, 0);            chk("ram_rdw_new", data_in, 32'h1);

    for (int i = 0; i < 9; i++) cyc(A_TX, 32'h41 + i, 1, 0, 0);
    cyc(A_CNT, 0, 0, 0, 0);             chk("fill_count", data_in, 32'd8);
    cyc(A_ST, 0, 0, 0, 0);              chk("fill_status", data_in, 32'h6);
    cyc(A_ST, 32'h4, 1, 0, 0);
    cyc(A_ST, 0, 0, 0, 0);              chk("ovf_clear", data_in, 32'h2);
    for (int i = 0; i < 8; i++) begin
      cyc(A_ST, 0, 0, 1, 0);
      chk("drain_data", {24'h0, tx_data}, 32'h41 + i);
    end
    cyc(A_ST, 0, 0, 1, 0);
    chk("drain_valid", {31'h0, tx_valid}, 32'h0);
    chk("drain_status", data_in, 32'h1);

    for (int i = 0; i < 8; i++) cyc(A_TX, 32'h30 + i, 1, 0, 0);
    cyc(A_TX, 32'h5A, 1, 1, 0);
    cyc(A_CNT, 0, 0, 0, 0);             chk("pp_count", data_in, 32'd8);
    cyc(A_ST, 0, 0, 0, 0);              chk("pp_status", data_in, 32'h2);
    for (int i = 0; i < 8; i++) begin
      cyc(A_ST, 0, 0, 1, 0);
      chk("pp_order", {24'h0, tx_data}, (i < 7) ? 32'h31 + i : 32'h5A);
    end

    cyc(32'h8000_0000, 32'h1, 1, 0, 0);
    chk("unm_rd", data_in, 32'h0);
    chk("fault_pre", {31'h0, mem_fault}, 32'h0);
    cyc(32'h8000_0000, 0, 0, 0, 0);     chk("fault_set", {31'h0, mem_fault}, 32'h1);
    cyc(32'hFFFF_0040, 32'h1, 1, 0, 0);
    cyc(32'h10, 0, 0, 0, 0);
    chk("fault_hold", {31'h0, mem_fault}, 32'h1);
    chk("ram_kept", data_in, 32'h1);

    cyc(A_LED, 32'hA5, 1, 0, 0);
    cyc(A_TX, 32'h77, 1, 0, 0);         chk("led_set", {24'h0, led}, 32'hA5);
    cyc(A_CYC, 0, 0, 0, 0);             chk("tx_pending", {31'h0, tx_valid}, 32'h1);
    #1 rst = 1;
    #1;
    chk("arst_cycle", data_in, 32'h0);
    chk("arst_led", {24'h0, led}, 32'h0);
    chk("arst_valid", {31'h0, tx_valid}, 32'h0);
    chk("arst_fault", {31'h0, mem_fault}, 32'h0);
    @(negedge clk);
    rst = 0;

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a, d;
      int k;
      k = $urandom_range(0, 19);
      if (k < 8)       a = {20'h0, 6'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
      else if (k == 8) a = 32'h0000_0FFC | 32'($urandom_range(0, 3));
      else if (k < 17) begin
        case ($urandom_range(0, 7))
          0: a = A_CYC; 1: a = A_LED; 2, 3: a = A_TX; 4: a = A_ST;
          5: a = A_CNT; 6: a = 32'hFFFF_0014; default: a = 32'hFFFF_0040;
        endcase
        a[15:8] = 8'($urandom);
        a[1:0]  = 2'($urandom);
      end
      else if (k == 17) a = 32'h0000_1000 | 32'($urandom_range(0, 3));
      else              a = 32'h8000_0000 | $urandom;
      d = $urandom;
      if ($urandom_range(0, 1) == 1) d[2] = 1'b0;
      cyc(a, d, ($urandom_range(0, 9) < 5) && (k < 17 || $urandom_range(0, 7) == 0),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 599) == 0));
    end
    cyc(A_CYC, 0, 0, 0, 0);
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Responder end of the processor data-memory bus. It takes data_addr, data_out and data_wr from the MEM stage and returns data_in in the same cycle. The address space holds a word-addressed RAM and a small MMIO page: a free-running cycle counter, an LED register, and a console transmit FIFO. The FIFO drains over a valid/ready byte handshake. The block sits beside the processor at the top level, in place of a bare data RAM.

Parameters:
MEM_WORDS, 1024, RAM depth in 32-bit words; power of two.
FIFO_DEPTH, 8, console TX FIFO entries; power of two, at least 2.
MMIO_PAGE, 16'hFFFF, value of data_addr[31:16] that selects the MMIO page.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset; asynchronous, active-high.
data_addr  in  32  byte address from processor; bits [1:0] ignored.
data_out  in  32  write data from processor.
data_wr  in  1  write strobe; one write per cycle in which it is high.
data_in  out  32  read data to processor; combinational from data_addr.
mem_fault  out  1  sticky flag; a write hit an unmapped address.
tx_data  out  8  byte at the head of the FIFO.
tx_valid  out  1  FIFO is non-empty.
tx_ready  in  1  sink accepts the byte; a pop occurs when tx_valid and tx_ready are both high.
led  out  8  LED register.

Behaviour:
- Decode:
  - MMIO when data_addr[31:16]==MMIO_PAGE.
  - Else RAM when data_addr[31:2] < MEM_WORDS.
  - Else unmapped.
- RAM:
  - Index is data_addr[log2(MEM_WORDS)+1:2].
  - Write happens at posedge when data_wr is high.
  - Read is asynchronous. A read during a write to the same word returns the old word; the new word is visible the next cycle.
  - RAM contents are not affected by rst.
- Unmapped: read returns 0. A write is dropped and sets mem_fault at that edge. mem_fault clears only on rst.
- MMIO offsets (data_addr[7:0]):
  - 0x00 CYCLE: read-only 32-bit counter. Increments every cycle and wraps 32'hFFFFFFFF to 0. Writes ignored.
  - 0x04 LED: read/write. Write loads data_out[7:0]. Read returns {24'b0, led}.
  - 0x08 TXDATA: write pushes data_out[7:0] into the FIFO. Read returns 0.
  - 0x0C STATUS: read returns {29'b0, ovf, full, empty}. A write with data_out[2]=1 clears ovf; other bits are ignored.
  - 0x10 COUNT: read returns FIFO occupancy, zero-extended. Writes ignored.
  - Any other offset in the page: read 0. A write is dropped and sets mem_fault.
- FIFO:
  - Circular buffer with read pointer, write pointer and occupancy count. Count width is clog2(FIFO_DEPTH+1).
  - tx_valid = (count != 0). tx_data = entry at the read pointer.
  - A push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - A rejected push sets ovf (sticky) and drops the byte.
  - Push and pop in the same cycle: count is unchanged and both pointers advance.
  - Push when empty: tx_valid rises the next cycle. There is no bypass.
  - Pointers wrap modulo FIFO_DEPTH.
  - tx_data must stay stable while tx_valid is high and tx_ready is low.
- Reset: all of the following are cleared to 0: CYCLE, led, FIFO pointers and count, ovf, mem_fault. Resulting outputs: tx_valid=0, tx_data=0, led=0, mem_fault=0. data_in follows decode and is 0 for MMIO CYCLE.
- Reset mid-operation: FIFO contents are discarded and any byte being offered on tx_data is abandoned.
- Latency: 0-cycle read; a write takes effect at the next edge. There are no stalls, and the processor never waits.

Decomposition:
- Shared package dmem_pkg:
  - MMIO offset constants: OFF_CYCLE, OFF_LED, OFF_TXDATA, OFF_STATUS, OFF_COUNT.
  - STATUS bit positions: ST_EMPTY=0, ST_FULL=1, ST_OVF=2.
  - Region-select enum: REG_RAM, REG_MMIO, REG_UNMAPPED.
- Sub-module tx_fifo:
  - Parameterised by width 8 and FIFO_DEPTH.
  - Ports: clk, rst, push, push_data, pop, head, count, full, empty, push_rejected.
- The top level holds the decode, RAM, counter, LED register, flags and read mux.

Test Plan:
1. RAM write/read: write 32'hDEADBEEF to 0x0000_0010, then read 0x0000_0010 and 0x0000_0013 → both return 32'hDEADBEEF. Same-cycle read of 0x10 during a write of 32'h1 → returns 32'hDEADBEEF; the next cycle returns 32'h1.
2. CYCLE and reset: release rst, wait 5 cycles, read 0xFFFF_0000 → 5. Assert rst asynchronously mid-cycle → CYCLE=0, led=0, tx_valid=0 immediately, before the next edge.
3. FIFO fill/overflow: hold tx_ready=0 and write 0x41..0x49 to TXDATA (9 bytes, FIFO_DEPTH=8) → COUNT=8, STATUS=32'h6 (full, ovf). Write STATUS with 32'h4 → STATUS=32'h2.
4. Drain: from step 3, hold tx_ready=1 → tx_data delivers 0x41..0x48 on consecutive cycles, then tx_valid=0 and STATUS=32'h1.
5. Push+pop at full: fill to 8, then in one cycle write 0x5A with tx_ready=1 → COUNT stays 8, ovf stays 0, and 0x5A emerges 8th.
6. Fault: write 32'h1 to 0x8000_0000 (MEM_WORDS=1024) → mem_fault=1 after the edge and the read returns 0. Write to 0xFFFF_0040 → mem_fault stays 1. Only rst clears it.
